// File: rtl/pns_axil_reg_slave.sv
// Purpose: AXI4-Lite register slave for the PNS control/parameter bank.
// Latency: BVALID and RVALID rise 1 cycle after the completing handshake; reg_q updates with BVALID.
// Backpressure: one write and one read outstanding; READYs drop while a response waits for BREADY/RREADY.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN    clock, async active-low reset
//   S_AXI_AW* / W* / B*           write address, write data, write response channels
//   S_AXI_AR* / R*                read address, read data channels
//   reg_q                         flat register contents, reg i at [32*i +: 32]
//   reg_wr_pulse                  one-cycle strobe per register on each OKAY write
module pns_axil_reg_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              aw_rdy_q, w_rdy_q, ar_rdy_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_in_range, rd_in_range;
  logic [DATA_W-1:0] rd_word;
  logic              unused_bits;

  // PROT is not used and the low address bits select bytes within a word.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

  // READYs come straight from flops loaded with the next-state decode, so
  // there is never a combinational VALID->READY path.
  assign aw_hs = S_AXI_AWVALID & aw_rdy_q;
  assign w_hs  = S_AXI_WVALID  & w_rdy_q;
  assign ar_hs = S_AXI_ARVALID & ar_rdy_q;

  assign S_AXI_AWREADY = aw_rdy_q;
  assign S_AXI_WREADY  = w_rdy_q;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  // Whichever half arrived first was latched; the other is taken live.
  assign wr_addr     = (w_state == W_HAVE_AW) ? awaddr_q : S_AXI_AWADDR;
  assign wr_data     = (w_state == W_HAVE_W)  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb     = (w_state == W_HAVE_W)  ? wstrb_q  : S_AXI_WSTRB;
  assign wr_idx      = wr_addr[ADDR_W-1:2];
  assign rd_idx      = S_AXI_ARADDR[ADDR_W-1:2];
  assign wr_in_range = ({1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS));
  assign rd_in_range = ({1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS));

  // Write FSM next state
  always_comb begin
    w_next    = w_state;
    wr_commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_AW;
        else if (w_hs)     w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_next = W_RESP;
      W_HAVE_W:  if (aw_hs) w_next = W_RESP;
      W_RESP:    if (S_AXI_BREADY) w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
    wr_commit = (w_state != W_RESP) && (w_next == W_RESP);
  end

  // Read FSM next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_word = regs[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      aw_rdy_q <= 1'b0;
      w_rdy_q  <= 1'b0;
      ar_rdy_q <= 1'b0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      aw_rdy_q <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
      w_rdy_q  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
      ar_rdy_q <= (r_next == R_IDLE);
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Register bank and write strobes; the strobe fires even for WSTRB=0.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= wr_commit && wr_in_range && (wr_idx == IDX_W'(i));
        if (wr_commit && wr_in_range && (wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read data is captured at the AR handshake, before any same-edge write lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in_range ? rd_word : '0;
      rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
      assign reg_q[DATA_W*g +: DATA_W] = regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_pns_axil_reg_slave.sv
// Bench for pns_axil_reg_slave: directed scenarios plus randomized traffic,
// all cycles checked against a transaction-level model of the register bank.
module tb_pns_axil_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [127:0] reg_q;
  logic [3:0]  reg_wr_pulse;

  always #5 clk = ~clk;

  pns_axil_reg_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A channel accepts when nothing of its kind is held or awaiting response.
  // READYs come up one clock after reset release (live).
  logic [31:0] mreg [4];
  bit          aw_held, w_held, b_pend, r_pend, live;
  logic [4:0]  aw_addr_h;
  logic [31:0] w_dat_h, r_dat_e;
  logic [3:0]  w_strb_h, pulse_e;
  logic [1:0]  b_resp_e, r_resp_e;
  int          pulse_cnt [4];
  int          pulse_total = 0;

  initial begin
    bit ea, ew, er;
    int ridx, widx;
    for (int i = 0; i < 4; i++) begin mreg[i] = 0; pulse_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_outputs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, reg_wr_pulse}, '0);
        chk("rst_rdata", RDATA, '0);
        chk("rst_reg_q", reg_q, '0);
        for (int i = 0; i < 4; i++) mreg[i] = 0;
        aw_held = 0; w_held = 0; b_pend = 0; r_pend = 0; live = 0; pulse_e = 0;
      end else begin
        ea = live && !b_pend && !aw_held;
        ew = live && !b_pend && !w_held;
        er = live && !r_pend;
        chk("reg_q", reg_q, {mreg[3], mreg[2], mreg[1], mreg[0]});
        chk("wr_pulse", reg_wr_pulse, pulse_e);
        chk("awready", AWREADY, ea);
        chk("wready", WREADY, ew);
        chk("arready", ARREADY, er);
        chk("bvalid", BVALID, b_pend);
        if (b_pend) chk("bresp", BRESP, b_resp_e);
        chk("rvalid", RVALID, r_pend);
        if (r_pend) begin
          chk("rdata", RDATA, r_dat_e);
          chk("rresp", RRESP, r_resp_e);
        end
        for (int i = 0; i < 4; i++) begin
          pulse_cnt[i] += int'(reg_wr_pulse[i]);
          pulse_total  += int'(reg_wr_pulse[i]);
        end
        // advance to the state after the coming rising edge
        pulse_e = 0;
        if (b_pend && BREADY) b_pend = 0;
        if (r_pend && RREADY) r_pend = 0;
        if (ARVALID && er) begin
          ridx   = int'(ARADDR[4:2]);
          r_pend = 1;
          if (ridx < 4) begin r_dat_e = mreg[ridx]; r_resp_e = 2'b00; end
          else          begin r_dat_e = 0;          r_resp_e = 2'b10; end
        end
        if (AWVALID && ea) begin aw_held = 1; aw_addr_h = AWADDR; end
        if (WVALID && ew)  begin w_held = 1; w_dat_h = WDATA; w_strb_h = WSTRB; end
        if (aw_held && w_held) begin
          widx = int'(aw_addr_h[4:2]);
          if (widx < 4) begin
            for (int b = 0; b < 4; b++)
              if (w_strb_h[b]) mreg[widx][8*b +: 8] = w_dat_h[8*b +: 8];
            pulse_e  = 4'(1 << widx);
            b_resp_e = 2'b00;
          end else begin
            b_resp_e = 2'b10;
          end
          b_pend = 1; aw_held = 0; w_held = 0;
        end
        live = 1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int hold,
                           output logic [1:0] resp, output int cycles);
    int t = 0;
    bit aw_done = 0, w_done = 0;
    BREADY = (hold == 0);
    while (!(aw_done && w_done) && t < 40) begin
      AWVALID = !aw_done && (t >= aw_dly); AWADDR = a;
      WVALID  = !w_done && (t >= w_dly);   WDATA = d; WSTRB = s;
      @(negedge clk);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY)   w_done = 1;
      cyc();
      t++;
    end
    AWVALID = 0; WVALID = 0; cycles = t;
    chk("wr_handshakes", {aw_done, w_done}, 2'b11);
    chk("bvalid_latency", BVALID, 1'b1);
    resp = BRESP;
    for (int k = 0; k < hold; k++) begin
      cyc();
      chk("b_hold_stable", {BVALID, BRESP}, {1'b1, resp});
      chk("b_hold_ready", {AWREADY, WREADY}, 2'b00);
    end
    BREADY = 1;
    cyc();
    chk("b_released", BVALID, 1'b0);
  endtask

  task automatic axi_read(input logic [4:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] r);
    int t = 0;
    bit done = 0;
    RREADY = (hold == 0); ARADDR = a;
    while (!done && t < 40) begin
      ARVALID = 1;
      @(negedge clk);
      if (ARREADY) done = 1;
      cyc();
      t++;
    end
    ARVALID = 0;
    chk("ar_handshake", done, 1'b1);
    chk("rvalid_latency", RVALID, 1'b1);
    d = RDATA; r = RRESP;
    for (int k = 0; k < hold; k++) begin
      cyc();
      chk("r_hold_stable", {RVALID, RRESP, RDATA}, {1'b1, r, d});
      chk("r_hold_ready", ARREADY, 1'b0);
    end
    RREADY = 1;
    cyc();
    chk("r_released", RVALID, 1'b0);
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, rr;
    logic [31:0] rd;
    int          ncyc, p0;
    bit          hs_aw, hs_w, hs_ar, gen;

    AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0; AWVALID = 0; WVALID = 0;
    WDATA = 0; WSTRB = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    cyc(); cyc();

    // 1: four full writes then read back
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i*4), 32'(i+1), 4'hF, 0, 0, 0, resp, ncyc);
      chk("t1_bresp", resp, 2'b00);
      chk("t1_cycles", ncyc, 1);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i*4), 0, rd, rr);
      chk("t1_rdata", rd, 32'(i+1));
      chk("t1_rresp", rr, 2'b00);
    end

    // 2: W first, AW three cycles later
    p0 = pulse_cnt[2];
    axi_write(5'h08, 32'h12345678, 4'hF, 3, 0, 0, resp, ncyc);
    chk("t2_cycles", ncyc, 4);
    chk("t2_pulses", pulse_cnt[2] - p0, 1);

    // 3: byte-strobed write
    axi_write(5'h04, 32'h00000002, 4'hF, 0, 0, 0, resp, ncyc);
    axi_write(5'h04, 32'hAABBCCDD, 4'b0010, 0, 0, 0, resp, ncyc);
    axi_read(5'h04, 0, rd, rr);
    chk("t3_rdata", rd, 32'h0000CC02);

    // zero strobe still pulses, data unchanged
    p0 = pulse_cnt[3];
    axi_write(5'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0, resp, ncyc);
    chk("t3_zero_strb_pulse", pulse_cnt[3] - p0, 1);

    // 4: out of range
    p0 = pulse_total;
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, 1, 0, 0, resp, ncyc);
    chk("t4_bresp", resp, 2'b10);
    chk("t4_no_pulse", pulse_total - p0, 0);
    chk("t4_regs", reg_q, {32'h4, 32'h12345678, 32'h0000CC02, 32'h1});
    axi_read(5'h10, 0, rd, rr);
    chk("t4_rdata", rd, 32'h0);
    chk("t4_rresp", rr, 2'b10);
    axi_read(5'h0B, 0, rd, rr);
    chk("t4_low_bits_ignored", rd, 32'h12345678);

    // 5: response backpressure
    axi_read(5'h08, 5, rd, rr);
    chk("t5_rdata", rd, 32'h12345678);
    axi_write(5'h0C, 32'h00000055, 4'hF, 0, 0, 5, resp, ncyc);
    chk("t5_bresp", resp, 2'b00);

    // 6: reset while BVALID is high
    BREADY = 0; AWADDR = 5'h00; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    @(negedge clk);
    chk("t6_ready", {AWREADY, WREADY}, 2'b11);
    cyc();
    AWVALID = 0; WVALID = 0;
    chk("t6_bvalid", BVALID, 1'b1);
    chk("t6_reg0", reg_q[31:0], 32'hCAFEF00D);
    #2 rst_n = 0;
    #1;
    chk("t6_bvalid_reset", BVALID, 1'b0);
    chk("t6_regq_reset", reg_q, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    BREADY = 1;
    cyc(); cyc();
    axi_write(5'h04, 32'h00000077, 4'hF, 0, 0, 0, resp, ncyc);
    chk("t6_post_bresp", resp, 2'b00);
    axi_read(5'h04, 0, rd, rr);
    chk("t6_post_rdata", rd, 32'h77);
    axi_read(5'h00, 0, rd, rr);
    chk("t6_reg0_cleared", rd, 32'h0);

    // randomized concurrent traffic, then drain
    for (int c = 0; c < 2600; c++) begin
      @(negedge clk);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      hs_ar = ARVALID && ARREADY;
      cyc();
      gen = (c < 2500);
      if (!AWVALID || hs_aw) begin
        AWVALID = gen && ($urandom_range(0, 2) != 0);
        AWADDR  = rand_addr();
      end
      if (!WVALID || hs_w) begin
        WVALID = gen && ($urandom_range(0, 2) != 0);
        WDATA  = $urandom;
        WSTRB  = 4'($urandom_range(0, 15));
      end
      if (!ARVALID || hs_ar) begin
        ARVALID = gen && ($urandom_range(0, 2) != 0);
        ARADDR  = rand_addr();
      end
      BREADY = !gen || ($urandom_range(0, 3) != 0);
      RREADY = !gen || ($urandom_range(0, 3) != 0);
    end
    chk("drain_idle", {AWVALID, WVALID, ARVALID, BVALID, RVALID}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
